// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writebacks with multi-cycle unit results onto one register file write port.
// Define ARB_STARVE_EN to enable the loss counter, FORCE state and stall_req.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_address,
    input  logic [31:0] wb_data,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_address,
    input  logic [31:0] mc_data,
    output logic [4:0]  rd_address,
    output logic [31:0] rd_data,
    output logic        pending_valid,
    output logic [4:0]  pending_address,
    output logic        stall_req
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

`ifdef ARB_STARVE_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HELD = 2'd1, ST_FORCE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HELD = 2'd1} state_t;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_buf_addr;
    logic [31:0] r_buf_data;

    logic w_buf_full;
    logic w_wb_win;
    logic w_mc_accept;
    logic w_drain;

    assign w_buf_full  = (r_state != ST_IDLE);
    assign w_wb_win    = wb_valid && (wb_address != 5'd0);
    assign mc_ready    = !w_buf_full && !reset;
    assign w_mc_accept = mc_valid && mc_ready;
    // A matching pipeline write is younger, so it retires the held entry too.
    assign w_drain     = w_buf_full && (!w_wb_win || (wb_address == r_buf_addr));

    always_comb begin
        rd_address = 5'd0;
        rd_data    = 32'd0;
        if (!reset) begin
            if (w_wb_win) begin
                rd_address = wb_address;
                rd_data    = wb_data;
            end else if (w_buf_full) begin
                rd_address = r_buf_addr;
                rd_data    = r_buf_data;
            end
        end
    end

    assign pending_valid   = w_buf_full;
    assign pending_address = w_buf_full ? r_buf_addr : 5'd0;

`ifdef ARB_STARVE_EN
    logic [3:0] r_loss_cnt;
    logic [3:0] w_cnt_next;
    logic [3:0] w_cnt_sat;
    logic       r_stall_req;

    assign w_cnt_sat = (r_loss_cnt == 4'hF) ? 4'hF : r_loss_cnt + 4'd1;
    assign stall_req = r_stall_req;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_loss_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_mc_accept && (mc_address != 5'd0)) w_state_next = ST_HELD;
            end
            ST_HELD: begin
                if (w_drain) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 4'd0;
                end else if (w_cnt_sat >= 4'(STARVE_LIMIT)) begin
                    w_state_next = ST_FORCE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next   = w_cnt_sat;
                end
            end
            ST_FORCE: begin
                if (w_drain) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_loss_cnt  <= 4'd0;
            r_stall_req <= 1'b0;
        end else begin
            r_loss_cnt  <= w_cnt_next;
            r_stall_req <= (w_state_next == ST_FORCE);
        end
    end
`else
    assign stall_req = 1'b0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mc_accept && (mc_address != 5'd0)) w_state_next = ST_HELD;
            end
            ST_HELD: begin
                if (w_drain) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_buf_addr <= 5'd0;
            r_buf_data <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_mc_accept && (mc_address != 5'd0)) begin
                r_buf_addr <= mc_address;
                r_buf_data <= mc_data;
            end else if (w_drain) begin
                r_buf_addr <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; stall expectations follow the ARB_STARVE_EN build.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_address;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_address;
    logic [31:0] mc_data;
    logic [4:0]  rd_address;
    logic [31:0] rd_data;
    logic        pending_valid;
    logic [4:0]  pending_address;
    logic        stall_req;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ARB_STARVE_EN
    localparam logic STARVE_BUILD = 1'b1;
`else
    localparam logic STARVE_BUILD = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .wb_valid        (wb_valid),
        .wb_address      (wb_address),
        .wb_data         (wb_data),
        .mc_valid        (mc_valid),
        .mc_ready        (mc_ready),
        .mc_address      (mc_address),
        .mc_data         (mc_data),
        .rd_address      (rd_address),
        .rd_data         (rd_data),
        .pending_valid   (pending_valid),
        .pending_address (pending_address),
        .stall_req       (stall_req)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        wb_valid = wv; wb_address = wa; wb_data = wd;
        mc_valid = mv; mc_address = ma; mc_data = md;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd6, 32'h0000_0666);
        next_cycle();
        settle();
        check("rst_rd_addr",  32'(rd_address), 32'd0);
        check("rst_rd_data",  rd_data, 32'd0);
        check("rst_mc_ready", 32'(mc_ready), 32'd0);
        check("rst_pending",  32'(pending_valid), 32'd0);
        check("rst_pend_adr", 32'(pending_address), 32'd0);
        check("rst_stall",    32'(stall_req), 32'd0);

        // x5 = 0x1234 with no pipeline traffic
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
        settle();
        check("t1_ready",    32'(mc_ready), 32'd1);
        check("t1_no_write", 32'(rd_address), 32'd0);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        check("t1_rd_addr",  32'(rd_address), 32'd5);
        check("t1_rd_data",  rd_data, 32'h0000_1234);
        check("t1_pend_adr", 32'(pending_address), 32'd5);
        check("t1_busy",     32'(mc_ready), 32'd0);
        next_cycle();
        settle();
        check("t1_ready_again", 32'(mc_ready), 32'd1);
        check("t1_pend_clear",  32'(pending_valid), 32'd0);
        check("t1_idle_rd",     32'(rd_address), 32'd0);

        // held x7 loses to x3 writes every cycle
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0077);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'h0000_0300 + 32'(i), 1'b0, 5'd0, 32'd0);
            settle();
            check($sformatf("t2_wb_win%0d", i), 32'(rd_address), 32'd3);
            check($sformatf("t2_nostall%0d", i), 32'(stall_req), 32'd0);
            next_cycle();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        check("t2_stall_up",  32'(stall_req), 32'(STARVE_BUILD));
        check("t2_bubble_a",  32'(rd_address), 32'd7);
        check("t2_bubble_d",  rd_data, 32'h0000_0077);
        next_cycle();
        settle();
        check("t2_stall_down", 32'(stall_req), 32'd0);
        check("t2_pend_clear", 32'(pending_valid), 32'd0);

        // WAW: younger x9 write replaces held x9
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_AAAA);
        next_cycle();
        drive(1'b1, 5'd9, 32'h0000_5555, 1'b0, 5'd0, 32'd0);
        settle();
        check("t3_rd_addr", 32'(rd_address), 32'd9);
        check("t3_rd_data", rd_data, 32'h0000_5555);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        check("t3_pend_drop", 32'(pending_valid), 32'd0);
        check("t3_no_stale",  32'(rd_address), 32'd0);
        check("t3_no_data",   rd_data, 32'd0);

        // mc result to x0 is swallowed
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        settle();
        check("t4_ready", 32'(mc_ready), 32'd1);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        check("t4_pend",  32'(pending_valid), 32'd0);
        check("t4_no_wr", 32'(rd_address), 32'd0);
        check("t4_ready2", 32'(mc_ready), 32'd1);

        // wb_valid to x0 does not claim the port
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_0044);
        next_cycle();
        drive(1'b1, 5'd0, 32'h0000_0F0F, 1'b0, 5'd0, 32'd0);
        settle();
        check("t5_rd_addr", 32'(rd_address), 32'd4);
        check("t5_rd_data", rd_data, 32'h0000_0044);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // reset while x12 is held
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0000_000C);
        next_cycle();
        drive(1'b1, 5'd3, 32'h0000_0003, 1'b0, 5'd0, 32'd0);
        settle();
        check("t6_held", 32'(pending_address), 32'd12);
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        check("t6_rst_rd",    32'(rd_address), 32'd0);
        check("t6_rst_ready", 32'(mc_ready), 32'd0);
        next_cycle();
        reset = 1'b0;
        settle();
        check("t6_pend",  32'(pending_valid), 32'd0);
        check("t6_no_wr", 32'(rd_address), 32'd0);
        check("t6_stall", 32'(stall_req), 32'd0);
        check("t6_ready", 32'(mc_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles a held multi-cycle result may lose arbitration before the pipeline is stalled (range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port wb_valid  input  1  the pipeline writeback presents a write this cycle.
REQ-005 SHALL have port wb_address  input  5  pipeline destination register.
REQ-006 SHALL have port wb_data  input  32  pipeline write data.
REQ-007 SHALL have port mc_valid  input  1  the multi-cycle unit (divider/long ops) offers a result.
REQ-008 SHALL have port mc_ready  output  1  the arbiter accepts the mc result this cycle.
REQ-009 SHALL have port mc_address  input  5  mc destination register.
REQ-010 SHALL have port mc_data  input  32  mc result data.
REQ-011 SHALL have port rd_address  output  5  register file write address; 0 means no write.
REQ-012 SHALL have port rd_data  output  32  register file write data.
REQ-013 SHALL have port pending_valid  output  1  a held mc result is not yet written.
REQ-014 SHALL have port pending_address  output  5  destination of the held mc result, for the decode interlock.
REQ-015 SHALL have port stall_req  output  1  registered request that the pipeline insert writeback bubbles.

Function
REQ-016 SHALL hold at most one mc result in a one-entry buffer (address, data); mc_ready = buffer empty and not in reset.
REQ-017 SHALL load the buffer on the rising edge ending a cycle with mc_valid and mc_ready high; a result with mc_address 0 SHALL be accepted and discarded (buffer stays empty).
REQ-018 SHALL write an accepted result no earlier than the cycle after acceptance (1-cycle minimum latency).
REQ-019 SHALL give the pipeline fixed priority: wb_valid high and wb_address nonzero drives rd_address/rd_data = wb_address/wb_data combinationally.
REQ-020 SHALL otherwise, with the buffer full, drive rd_address/rd_data from the buffer and clear the buffer at the next edge; else drive rd_address = 0, rd_data = 0.
REQ-021 SHALL implement states IDLE (buffer empty), HELD (buffer full, counting losses), FORCE (stall_req high).
REQ-022 SHALL transition IDLE->HELD on mc acceptance; HELD->IDLE when the buffer drains; HELD->FORCE when the loss counter reaches STARVE_LIMIT; FORCE->IDLE when the buffer drains.
REQ-023 SHALL increment the 4-bit loss counter each HELD cycle in which the pipeline wins, saturating, and clear it on leaving HELD.
REQ-024 SHALL, if wb_valid with wb_address equal to a nonzero held address occurs (younger write, WAW), write the pipeline value and discard the held entry at the next edge.
REQ-025 SHALL, in FORCE with wb_valid high (protocol violation), still grant the pipeline and remain in FORCE.
REQ-026 SHALL drive pending_valid = buffer full and pending_address = held address (0 when empty).

Reset
REQ-027 SHALL, while reset is high, force rd_address = 0, rd_data = 0, mc_ready = 0; at the edge set state IDLE, buffer empty, counter 0, stall_req 0, pending_valid 0, pending_address 0.
REQ-028 SHALL discard a held result when reset is asserted mid-operation, without writing it.

Configuration
REQ-029 SHALL, with macro ARB_STARVE_EN defined, implement the loss counter, FORCE state and stall_req as above.
REQ-030 SHALL, without ARB_STARVE_EN, omit the counter and FORCE, tie stall_req to 0, and hold a result in HELD until a free write slot occurs.

Verification
REQ-031 SHALL cover: mc result x5=0x0000_1234 accepted, no wb traffic -> rd_address=5, rd_data=0x1234 next cycle, mc_ready high the cycle after.
REQ-032 SHALL cover: held x7, wb writes x3 every cycle, STARVE_LIMIT=4 -> stall_req rises after 4 losses; first bubble writes x7; stall_req drops the next cycle.
REQ-033 SHALL cover: held x9=0xAAAA, wb writes x9=0x5555 -> rd_data=0x5555, pending_valid drops, 0xAAAA never written.
REQ-034 SHALL cover: mc_valid with mc_address=0 -> accepted, pending_valid stays 0, no write.
REQ-035 SHALL cover: reset asserted while x12 held -> no x12 write, all outputs at reset values; build without ARB_STARVE_EN -> stall_req constant 0 under REQ-032 stimulus.
